// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction-fetch stage.
//   ADDR_W / INSTR_W     : word-address and instruction widths
//   DEFAULT_RESET_PC     : PC loaded on reset
//   DEFAULT_HALT_WORD    : instruction encoding that stops fetch
//   fetch_state_t        : fetch FSM states (IDLE, RUN, HALT)
package fetch_pkg;

   localparam int unsigned ADDR_W  = 8;
   localparam int unsigned INSTR_W = 32;

   localparam logic [ADDR_W-1:0]  DEFAULT_RESET_PC  = 8'h00;
   localparam logic [INSTR_W-1:0] DEFAULT_HALT_WORD = 32'hFFFF_FFFF;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_HALT = 2'd2
   } fetch_state_t;

endpackage

// File: rtl/fetch_unit_if.sv
// Bus bundle between the fetch stage and its neighbours.
//   start, stall, redirect, redirect_addr : control from pipeline
//   direccion / instruccion               : InstructionMemory port
//   if_instr, if_pc, if_pc_next, if_valid : IF/ID register contents
//   halted                                : fetch stopped on halt word
// master = fetch_unit side, slave = environment side.
interface fetch_unit_if;
   import fetch_pkg::*;

   logic                start;
   logic                stall;
   logic                redirect;
   logic [ADDR_W-1:0]   redirect_addr;
   logic [ADDR_W-1:0]   direccion;
   logic [INSTR_W-1:0]  instruccion;
   logic [INSTR_W-1:0]  if_instr;
   logic [ADDR_W-1:0]   if_pc;
   logic [ADDR_W-1:0]   if_pc_next;
   logic                if_valid;
   logic                halted;

   modport master (
      input  start, stall, redirect, redirect_addr, instruccion,
      output direccion, if_instr, if_pc, if_pc_next, if_valid, halted
   );

   modport slave (
      output start, stall, redirect, redirect_addr, instruccion,
      input  direccion, if_instr, if_pc, if_pc_next, if_valid, halted
   );

endinterface

// File: rtl/fetch_unit_if_id_register.sv
// IF/ID pipeline register.
//   clk, rst_n      : clock, synchronous active-low reset (clears all)
//   load            : capture new_instr/new_pc, mark valid
//   flush           : clear valid only (wins over load)
//   neither         : hold
//   if_instr, if_pc, if_pc_next, if_valid : registered outputs
module if_id_register
   import fetch_pkg::*;
(
   input  logic               clk,
   input  logic               rst_n,
   input  logic               load,
   input  logic               flush,
   input  logic [INSTR_W-1:0] new_instr,
   input  logic [ADDR_W-1:0]  new_pc,
   output logic [INSTR_W-1:0] if_instr,
   output logic [ADDR_W-1:0]  if_pc,
   output logic [ADDR_W-1:0]  if_pc_next,
   output logic               if_valid
);

   // pc_next is registered rather than derived so it reads 0 after reset.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         if_instr   <= '0;
         if_pc      <= '0;
         if_pc_next <= '0;
         if_valid   <= 1'b0;
      end else if (flush) begin
         if_valid   <= 1'b0;
      end else if (load) begin
         if_instr   <= new_instr;
         if_pc      <= new_pc;
         if_pc_next <= new_pc + ADDR_W'(1);
         if_valid   <= 1'b1;
      end
   end

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: PC register, fetch FSM and IF/ID register.
//   clk, rst_n : clock, synchronous active-low reset
//   bus        : fetch_unit_if.master (control in, memory port, IF/ID out)
// Parameters: RESET_PC (PC after reset), HALT_WORD (stops fetch).
module fetch_unit
   import fetch_pkg::*;
#(
   parameter logic [ADDR_W-1:0]  RESET_PC  = DEFAULT_RESET_PC,
   parameter logic [INSTR_W-1:0] HALT_WORD = DEFAULT_HALT_WORD
)(
   input  logic          clk,
   input  logic          rst_n,
   fetch_unit_if.master  bus
);

   fetch_state_t       state_q, state_d;
   logic [ADDR_W-1:0]  pc_q, pc_d;
   logic               load, flush;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         pc_q    <= RESET_PC;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
      end
   end

   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      load    = 1'b0;
      flush   = 1'b0;
      unique case (state_q)
         ST_IDLE: begin
            if (bus.start) state_d = ST_RUN;
         end
         ST_RUN: begin
            if (bus.redirect) begin
               pc_d  = bus.redirect_addr;
               flush = 1'b1;
            end else if (!bus.stall) begin
               load = 1'b1;
               // Halt word is captured as a valid instruction; PC parks on it.
               if (bus.instruccion == HALT_WORD) state_d = ST_HALT;
               else                              pc_d    = pc_q + ADDR_W'(1);
            end
         end
         ST_HALT: begin
            if (bus.redirect) begin
               pc_d    = bus.redirect_addr;
               flush   = 1'b1;
               state_d = ST_RUN;
            end else if (!bus.stall) begin
               // Halt word is dropped once decode has consumed it.
               flush = 1'b1;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   assign bus.direccion = pc_q;
   assign bus.halted    = (state_q == ST_HALT);

   if_id_register u_if_id (
      .clk        (clk),
      .rst_n      (rst_n),
      .load       (load),
      .flush      (flush),
      .new_instr  (bus.instruccion),
      .new_pc     (pc_q),
      .if_instr   (bus.if_instr),
      .if_pc      (bus.if_pc),
      .if_pc_next (bus.if_pc_next),
      .if_valid   (bus.if_valid)
   );

endmodule
